rvfi_trace_buffer: RTL

Circular capture buffer that sits directly downstream of the RVFI retirement tracker and records each retired instruction (`rvfi_valid` pulse) into on-chip storage. It supports a PC-match trigger with a programmable post-trigger depth, after which capture stops and the buffer freezes. Frozen contents are read out word-by-word through a request/acknowledge port driven by the JTAG debug/DMI side. The block lets us inspect retirement history on silicon without a simulator-side tracer.

---
 rtl/rvfi_trace_buffer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rvfi_trace_buffer.sv
// rvfi_trace_buffer
//
// Circular capture buffer for retired instructions coming from the RVFI
// retirement tracker. After cfg_arm every rvfi_valid pulse is recorded.
// A PC match against cfg_trig_pc starts a bounded post-trigger window,
// after which capture stops and the buffer freezes for readout.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   rvfi_valid                   retirement strobe
//   rvfi_insn / rvfi_pc_rdata /
//   rvfi_pc_wdata / rvfi_rd_wdata retired instruction, PC, next PC, rd data
//   rvfi_rd_addr                 destination register
//   cfg_arm, cfg_clear           restart capture / return to idle (pulses)
//   cfg_trig_pc, cfg_post_cnt    trigger PC and post-trigger entry count
//   rd_req, rd_idx, rd_sel       readout request (idx 0 = oldest entry)
//   rd_ack, rd_data              readout response, one cycle later
//   state, count, trig_hit       status
module rvfi_trace_buffer #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rvfi_valid,
    input  logic [31:0]   rvfi_insn,
    input  logic [31:0]   rvfi_pc_rdata,
    input  logic [31:0]   rvfi_pc_wdata,
    input  logic [31:0]   rvfi_rd_wdata,
    input  logic [4:0]    rvfi_rd_addr,
    input  logic          cfg_arm,
    input  logic          cfg_clear,
    input  logic [31:0]   cfg_trig_pc,
    input  logic [CW-1:0] cfg_post_cnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_idx,
    input  logic [1:0]    rd_sel,
    output logic          rd_ack,
    output logic [31:0]   rd_data,
    output logic [1:0]    state,
    output logic [CW-1:0] count,
    output logic          trig_hit
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_POST   = 2'd2,
        S_FROZEN = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic          capture;
    logic          trig_match;
    logic [CW-1:0] post_clamped;

    logic [AW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   order_reg;
    logic [CW-1:0] post_left_reg;
    logic [31:0]   prev_npc_reg;
    logic          prev_npc_valid_reg;
    logic          trig_hit_reg;

    logic          rd_ack_reg;
    logic          rd_ok_reg;
    logic [1:0]    rd_sel_reg;
    logic          rd_ok;
    logic [AW-1:0] rd_phys;

    logic          disc;
    logic [3:0][31:0] wr_word;
    logic [3:0][31:0] bank_rd;

    // The window can never exceed the storage minus the trigger entry itself,
    // otherwise the trigger would be overwritten before freezing.
    assign post_clamped = (cfg_post_cnt > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : cfg_post_cnt;

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        trig_match = 1'b0;
        if (cfg_clear) begin
            state_next = S_IDLE;
        end else if (cfg_arm) begin
            state_next = S_ARMED;
        end else begin
            case (state_reg)
                S_ARMED: begin
                    if (rvfi_valid) begin
                        capture = 1'b1;
                        if (rvfi_pc_rdata == cfg_trig_pc) begin
                            trig_match = 1'b1;
                            state_next = (post_clamped == '0) ? S_FROZEN : S_POST;
                        end
                    end
                end
                S_POST: begin
                    if (rvfi_valid) begin
                        capture = 1'b1;
                        if (post_left_reg <= CW'(1)) begin
                            state_next = S_FROZEN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Capture bookkeeping
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg         <= '0;
            count_reg          <= '0;
            order_reg          <= '0;
            post_left_reg      <= '0;
            prev_npc_reg       <= '0;
            prev_npc_valid_reg <= 1'b0;
            trig_hit_reg       <= 1'b0;
        end else if (!cfg_clear && cfg_arm) begin
            wr_ptr_reg         <= '0;
            count_reg          <= '0;
            order_reg          <= '0;
            prev_npc_valid_reg <= 1'b0;
            trig_hit_reg       <= 1'b0;
        end else if (capture) begin
            wr_ptr_reg         <= wr_ptr_reg + AW'(1);
            if (count_reg != CW'(DEPTH)) begin
                count_reg <= count_reg + CW'(1);
            end
            order_reg          <= order_reg + 32'd1;
            prev_npc_reg       <= rvfi_pc_wdata;
            prev_npc_valid_reg <= 1'b1;
            if (trig_match) begin
                trig_hit_reg  <= 1'b1;
                post_left_reg <= post_clamped;
            end else if (state_reg == S_POST) begin
                post_left_reg <= post_left_reg - CW'(1);
            end
        end
    end

    // A jump is flagged when this PC differs from the previous entry's next PC.
    assign disc = prev_npc_valid_reg && (rvfi_pc_rdata != prev_npc_reg);

    assign wr_word[0] = rvfi_pc_rdata;
    assign wr_word[1] = rvfi_insn;
    assign wr_word[2] = rvfi_rd_wdata;
    assign wr_word[3] = {order_reg[15:0], 7'd0, disc, 3'd0, rvfi_rd_addr};

    // ---------------------------------------------------------------
    // Storage: one RAM bank per read word, registered read, no reset
    // ---------------------------------------------------------------
    assign rd_phys = wr_ptr_reg - count_reg[AW-1:0] + rd_idx;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bank
            logic [31:0] bank_mem [DEPTH];
            logic [31:0] bank_q;

            always_ff @(posedge clk) begin
                if (capture) begin
                    bank_mem[wr_ptr_reg] <= wr_word[gi];
                end
                if (rd_req) begin
                    bank_q <= bank_mem[rd_phys];
                end
            end

            assign bank_rd[gi] = bank_q;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Readout handshake
    // ---------------------------------------------------------------
    // Validity is judged on pre-edge state/count, so a request that
    // coincides with the freezing capture still returns zero.
    assign rd_ok = rd_req && (state_reg == S_FROZEN) && ({1'b0, rd_idx} < count_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack_reg <= 1'b0;
            rd_ok_reg  <= 1'b0;
            rd_sel_reg <= 2'd0;
        end else begin
            rd_ack_reg <= rd_req;
            rd_ok_reg  <= rd_ok;
            rd_sel_reg <= rd_sel;
        end
    end

    // The RAM output register is not reset; the reset-cleared valid flag
    // gates it so rd_data is zero whenever no valid word is presented.
    assign rd_ack   = rd_ack_reg;
    assign rd_data  = rd_ok_reg ? bank_rd[rd_sel_reg] : 32'd0;
    assign state    = state_reg;
    assign count    = count_reg;
    assign trig_hit = trig_hit_reg;

endmodule
